// File: rtl/regfile_wb_arbiter.sv
// Register-file writeback arbiter.
// After reset it walks every register and writes zero to it. Once that is
// done it arbitrates between the ALU (A) and load (B) writeback ports.
// Arbitration is round-robin, and the write to the register file is
// registered one cycle after the grant.
module regfile_wb_arbiter #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_REGS = 32,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              a_req,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_data,
    output logic              a_gnt,
    input  logic              b_req,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_data,
    output logic              b_gnt,
    output logic              rg_wrt_en,
    output logic [ADDR_W-1:0] rg_wrt_addr,
    output logic [DATA_W-1:0] rg_wrt_data,
    output logic              init_done,
    output logic [CNT_W-1:0]  conflict_cnt
);

    typedef enum logic {CLEAR, RUN} state_t;

    state_t            state;
    logic [ADDR_W-1:0] clr_cnt;
    logic              last_b;   // 1: the most recent grant went to B

    // Combinational grant. On a conflict the side not granted last wins.
    // Grants are suppressed while reset is asserted and while clearing.
    always_comb begin
        a_gnt = 1'b0;
        b_gnt = 1'b0;
        if (!reset && state == RUN) begin
            if (a_req && (!b_req || last_b))
                a_gnt = 1'b1;
            else if (b_req)
                b_gnt = 1'b1;
        end
    end

    // Clear/run FSM with registered write port, pointer and conflict counter
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= CLEAR;
            clr_cnt      <= '0;
            rg_wrt_en    <= 1'b0;
            rg_wrt_addr  <= '0;
            rg_wrt_data  <= '0;
            init_done    <= 1'b0;
            conflict_cnt <= '0;
            last_b       <= 1'b1;
        end else begin
            case (state)
                CLEAR: begin
                    rg_wrt_en   <= 1'b1;
                    rg_wrt_addr <= clr_cnt;
                    rg_wrt_data <= '0;
                    if (clr_cnt == ADDR_W'(NUM_REGS - 1)) begin
                        state     <= RUN;
                        init_done <= 1'b1;
                        clr_cnt   <= '0;
                    end else begin
                        clr_cnt <= clr_cnt + ADDR_W'(1);
                    end
                end
                RUN: begin
                    rg_wrt_en <= 1'b0;
                    // A write to x0 is granted but never issued. The address
                    // and data registers keep their previous values.
                    if (a_gnt) begin
                        last_b <= 1'b0;
                        if (a_addr != '0) begin
                            rg_wrt_en   <= 1'b1;
                            rg_wrt_addr <= a_addr;
                            rg_wrt_data <= a_data;
                        end
                    end else if (b_gnt) begin
                        last_b <= 1'b1;
                        if (b_addr != '0) begin
                            rg_wrt_en   <= 1'b1;
                            rg_wrt_addr <= b_addr;
                            rg_wrt_data <= b_data;
                        end
                    end
                    if (a_req && b_req && conflict_cnt != '1)
                        conflict_cnt <= conflict_cnt + CNT_W'(1);
                end
                default: state <= CLEAR;
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter. It covers the clear sequence,
// single grants, round-robin on conflicts, x0 suppression, reset during
// clear and during run, and saturation of the conflict counter.
module tb_regfile_wb_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        a_req, b_req;
    logic [4:0]  a_addr, b_addr;
    logic [31:0] a_data, b_data;
    logic        a_gnt, b_gnt;
    logic        rg_wrt_en;
    logic [4:0]  rg_wrt_addr;
    logic [31:0] rg_wrt_data;
    logic        init_done;
    logic [15:0] conflict_cnt;

    int total = 0;
    int bad   = 0;

    regfile_wb_arbiter dut (
        .clk(clk), .reset(reset),
        .a_req(a_req), .a_addr(a_addr), .a_data(a_data), .a_gnt(a_gnt),
        .b_req(b_req), .b_addr(b_addr), .b_data(b_data), .b_gnt(b_gnt),
        .rg_wrt_en(rg_wrt_en), .rg_wrt_addr(rg_wrt_addr), .rg_wrt_data(rg_wrt_data),
        .init_done(init_done), .conflict_cnt(conflict_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Wait for the next rising edge, then sample 1 time unit after it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Release reset and walk the full clear. Requests are held high the whole
    // time to show that nothing is granted before init_done.
    task automatic run_clear(input string tag);
        for (int i = 0; i < 32; i++) begin
            chk({tag, "_nogntA"}, 64'(a_gnt), 64'd0);
            chk({tag, "_nogntB"}, 64'(b_gnt), 64'd0);
            step();
            chk({tag, "_en"},   64'(rg_wrt_en), 64'd1);
            chk({tag, "_addr"}, 64'(rg_wrt_addr), 64'(i));
            chk({tag, "_data"}, 64'(rg_wrt_data), 64'd0);
            chk({tag, "_done"}, 64'(init_done), (i == 31) ? 64'd1 : 64'd0);
        end
    endtask

    initial begin
        reset = 1'b1;
        a_req = 1'b1; b_req = 1'b1;
        a_addr = 5'd3; b_addr = 5'd4;
        a_data = 32'h1111_1111; b_data = 32'h2222_2222;

        // Reset state
        step(); step();
        chk("rst_en",    64'(rg_wrt_en), 64'd0);
        chk("rst_addr",  64'(rg_wrt_addr), 64'd0);
        chk("rst_data",  64'(rg_wrt_data), 64'd0);
        chk("rst_done",  64'(init_done), 64'd0);
        chk("rst_cnt",   64'(conflict_cnt), 64'd0);
        chk("rst_gntA",  64'(a_gnt), 64'd0);
        chk("rst_gntB",  64'(b_gnt), 64'd0);

        // Clear sequence. No conflicts are counted while clearing.
        reset = 1'b0;
        run_clear("clr");
        chk("clr_cnt0", 64'(conflict_cnt), 64'd0);

        // Single A request at addr 5
        b_req = 1'b0;
        a_req = 1'b1; a_addr = 5'd5; a_data = 32'hDEAD_BEEF;
        #1;
        chk("solo_gntA", 64'(a_gnt), 64'd1);
        chk("solo_gntB", 64'(b_gnt), 64'd0);
        step();
        a_req = 1'b0;
        chk("solo_en",   64'(rg_wrt_en), 64'd1);
        chk("solo_addr", 64'(rg_wrt_addr), 64'd5);
        chk("solo_data", 64'(rg_wrt_data), 64'hDEAD_BEEF);

        // Idle cycle: enable drops, address and data hold
        step();
        chk("idle_en",   64'(rg_wrt_en), 64'd0);
        chk("idle_addr", 64'(rg_wrt_addr), 64'd5);
        chk("idle_data", 64'(rg_wrt_data), 64'hDEAD_BEEF);

        // B writes to x0: granted but no write. The pointer moves to B.
        b_req = 1'b1; b_addr = 5'd0; b_data = 32'h5555_5555;
        #1;
        chk("x0_gntB", 64'(b_gnt), 64'd1);
        chk("x0_gntA", 64'(a_gnt), 64'd0);
        step();
        chk("x0_en", 64'(rg_wrt_en), 64'd0);

        // Four-cycle conflict to the same register. Expect A,B,A,B; B's write lands last.
        a_req = 1'b1; a_addr = 5'd7; a_data = 32'hAAAA_1111;
        b_req = 1'b1; b_addr = 5'd7; b_data = 32'hBBBB_2222;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("rr_gntA", 64'(a_gnt), (k % 2 == 0) ? 64'd1 : 64'd0);
            chk("rr_gntB", 64'(b_gnt), (k % 2 == 1) ? 64'd1 : 64'd0);
            step();
            chk("rr_en",   64'(rg_wrt_en), 64'd1);
            chk("rr_addr", 64'(rg_wrt_addr), 64'd7);
            chk("rr_data", 64'(rg_wrt_data), (k % 2 == 0) ? 64'hAAAA_1111 : 64'hBBBB_2222);
        end
        chk("rr_cnt", 64'(conflict_cnt), 64'd4);

        // Reset during run. The pending grant is dropped and the counter clears.
        reset = 1'b1;
        #1;
        chk("rrun_gntA", 64'(a_gnt), 64'd0);
        chk("rrun_gntB", 64'(b_gnt), 64'd0);
        step();
        chk("rrun_en",   64'(rg_wrt_en), 64'd0);
        chk("rrun_done", 64'(init_done), 64'd0);
        chk("rrun_cnt",  64'(conflict_cnt), 64'd0);

        // Clear up to address 17, then pulse reset
        reset = 1'b0;
        for (int i = 0; i < 18; i++) begin
            step();
            chk("part_addr", 64'(rg_wrt_addr), 64'(i));
            chk("part_done", 64'(init_done), 64'd0);
        end
        reset = 1'b1;
        step();
        chk("pulse_en",   64'(rg_wrt_en), 64'd0);
        chk("pulse_addr", 64'(rg_wrt_addr), 64'd0);
        reset = 1'b0;
        run_clear("reclr");
        chk("reclr_cnt", 64'(conflict_cnt), 64'd0);

        // Saturate the conflict counter: 0xFFFE conflicts, then 3 more
        a_req = 1'b1; b_req = 1'b1;
        repeat (16'hFFFE) @(posedge clk);
        #1;
        chk("sat_fffe", 64'(conflict_cnt), 64'hFFFE);
        step(); step(); step();
        chk("sat_ffff", 64'(conflict_cnt), 64'hFFFF);

        a_req = 1'b0; b_req = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
